// File: rtl/qam_tx_pkg.sv
// rtl/qam_tx_pkg.sv - shared states and constants for the QAM transmit controller
// QAM_TX_CTRL_PREAMBLE_EN adds the PREAMBLE state and its pattern constants.
package qam_tx_pkg;

`ifdef QAM_TX_CTRL_PREAMBLE_EN
    typedef enum logic [2:0] {
        S_IDLE, S_GUARD, S_PREAMBLE, S_PAYLOAD, S_FLUSH
    } state_t;

    localparam logic [1:0] PRE_PAT0 = 2'b01;
    localparam logic [1:0] PRE_PAT1 = 2'b10;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_GUARD, S_PAYLOAD, S_FLUSH
    } state_t;
`endif

    localparam int DEF_PRE_LEN    = 8;
    localparam int DEF_FLUSH_SYMS = 4;

endpackage

// File: rtl/qam_sym_timer.sv
// rtl/qam_sym_timer.sv - 2-bit symbol phase counter with phase-3 terminal strobe
// Runs while en is high, held at zero otherwise, matching the 4x up-sampler.
module qam_sym_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [1:0] phase,
    output logic       term
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= 2'd0;
        end else if (en) begin
            phase <= phase + 2'd1;
        end else begin
            phase <= 2'd0;
        end
    end

    assign term = en && (phase == 2'd3);

endmodule

// File: rtl/qam_tx_ctrl.sv
// rtl/qam_tx_ctrl.sv - frame sequencer feeding symbols to a 4x up-sampler
// QAM_TX_CTRL_PREAMBLE_EN inserts an alternating preamble after the guard period.
module qam_tx_ctrl
    import qam_tx_pkg::*;
#(
    parameter int LEN_W      = 8,
    parameter int PRE_LEN    = DEF_PRE_LEN,
    parameter int FLUSH_SYMS = DEF_FLUSH_SYMS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] frame_len,
    input  logic [1:0]       sym_in,
    input  logic             sym_valid,
    output logic             sym_ready,
    output logic             us_en,
    output logic [1:0]       us_sym,
    output logic             busy,
    output logic             done,
    output logic             underrun
);

    state_t           state, state_n;
    logic [LEN_W-1:0] cnt, cnt_n;
    logic [LEN_W-1:0] len_q, len_n;
    logic [1:0]       sym_n;
    logic             und_n, done_n;
    logic             go_pay, go_flush, take;
    logic [1:0]       phase;
    logic             term;

    assign busy  = (state != S_IDLE);
    assign us_en = busy;

    qam_sym_timer u_timer (
        .clk   (clk),
        .rst   (rst),
        .en    (busy),
        .phase (phase),
        .term  (term)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            len_q    <= '0;
            us_sym   <= 2'd0;
            underrun <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            len_q    <= len_n;
            us_sym   <= sym_n;
            underrun <= und_n;
            done     <= done_n;
        end
    end

    // Every load of us_sym happens on a phase-3 edge, holding it for the whole period.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        len_n     = len_q;
        sym_n     = us_sym;
        und_n     = underrun;
        done_n    = 1'b0;
        go_pay    = 1'b0;
        go_flush  = 1'b0;
        take      = 1'b0;
        sym_ready = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_GUARD;
                    len_n   = frame_len;
                    und_n   = 1'b0;
                    sym_n   = 2'd0;
                end
            end
            S_GUARD: begin
                if (term) begin
`ifdef QAM_TX_CTRL_PREAMBLE_EN
                    state_n = S_PREAMBLE;
                    cnt_n   = LEN_W'(PRE_LEN - 1);
                    sym_n   = PRE_PAT0;
`else
                    go_pay  = 1'b1;
`endif
                end
            end
`ifdef QAM_TX_CTRL_PREAMBLE_EN
            S_PREAMBLE: begin
                if (term) begin
                    if (cnt == '0) begin
                        go_pay = 1'b1;
                    end else begin
                        cnt_n = cnt - 1'b1;
                        sym_n = (us_sym == PRE_PAT0) ? PRE_PAT1 : PRE_PAT0;
                    end
                end
            end
`endif
            S_PAYLOAD: begin
                if (term) begin
                    if (cnt == '0) begin
                        go_flush = 1'b1;
                    end else begin
                        cnt_n = cnt - 1'b1;
                        take  = 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                if (term) begin
                    if (cnt == '0) begin
                        state_n = S_IDLE;
                        done_n  = 1'b1;
                        sym_n   = 2'd0;
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase

        if (go_pay) begin
            if (len_q == '0) begin
                go_flush = 1'b1;
            end else begin
                state_n = S_PAYLOAD;
                cnt_n   = len_q - 1'b1;
                take    = 1'b1;
            end
        end
        if (go_flush) begin
            state_n = S_FLUSH;
            cnt_n   = LEN_W'(FLUSH_SYMS - 1);
            sym_n   = 2'd0;
        end
        // A missing symbol still consumes its period so frame timing never slips.
        if (take) begin
            sym_ready = 1'b1;
            if (sym_valid) begin
                sym_n = sym_in;
            end else begin
                sym_n = 2'd0;
                und_n = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_qam_tx_ctrl.sv
// tb/tb_qam_tx_ctrl.sv - directed self-checking bench for qam_tx_ctrl
module tb_qam_tx_ctrl;

`ifdef QAM_TX_CTRL_PREAMBLE_EN
    localparam int P = 8;
`else
    localparam int P = 0;
`endif
    localparam int FL = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] frame_len = 8'd0;
    logic [1:0] sym_in = 2'd0;
    logic       sym_valid = 1'b0;
    logic       sym_ready, us_en, busy, done, underrun;
    logic [1:0] us_sym;

    qam_tx_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .frame_len (frame_len),
        .sym_in    (sym_in),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .us_en     (us_en),
        .us_sym    (us_sym),
        .busy      (busy),
        .done      (done),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    logic [1:0] syms [0:255];
    logic       vld  [0:255];
    logic [1:0] rec  [0:2047];
    int nrec, en_cnt, done_cnt, rdy_cnt, rdy_bad, busy_bad, first_und, extra_done;
    int restart_at = -1;

    task automatic fill_default();
        for (int i = 0; i < 256; i++) begin
            syms[i] = 2'(i % 4);
            vld[i]  = 1'b1;
        end
    endtask

    task automatic run_frame(input int len);
        int hs;
        bit fin;
        @(negedge clk);
        frame_len = 8'(len);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hs = 0; nrec = 0; en_cnt = 0; done_cnt = 0; rdy_cnt = 0;
        rdy_bad = 0; busy_bad = 0; fin = 0;
        first_und = underrun;
        for (int cyc = 0; cyc < 1300 && !fin; cyc++) begin
            if (cyc == restart_at) begin
                start = 1'b1;
                frame_len = 8'd7;
            end else begin
                start = 1'b0;
            end
            sym_in    = syms[hs & 255];
            sym_valid = vld[hs & 255];
            if (busy !== us_en) busy_bad++;
            if (us_en) begin
                if (nrec < 2048) rec[nrec] = us_sym;
                if (sym_ready) begin
                    rdy_cnt++;
                    if (nrec % 4 != 3) rdy_bad++;
                    hs++;
                end
                nrec++;
                en_cnt++;
            end else if (sym_ready) begin
                rdy_bad++;
            end
            if (done) begin
                done_cnt++;
                fin = 1;
                if (busy) busy_bad++;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check_val("frame_completes", int'(fin), 1);
        extra_done = int'(done);
    endtask

    function automatic int exp_sym(input int k, input int len);
        int i;
        if (k == 0) return 0;
        if (k <= P) return (k % 2 == 1) ? 1 : 2;
        if (k <= P + len) begin
            i = k - 1 - P;
            return vld[i] ? int'(syms[i]) : 0;
        end
        return 0;
    endfunction

    task automatic verify(input string tag, input int len);
        int periods, unstable, idx;
        periods = 1 + P + len + FL;
        check_val({tag, "_en_cycles"}, en_cnt, 4 * periods);
        check_val({tag, "_done_pulses"}, done_cnt, 1);
        check_val({tag, "_done_one_cycle"}, extra_done, 0);
        check_val({tag, "_ready_count"}, rdy_cnt, len);
        check_val({tag, "_ready_off_phase3"}, rdy_bad, 0);
        check_val({tag, "_busy_tracks_en"}, busy_bad, 0);
        unstable = 0;
        for (int k = 0; k < periods; k++) begin
            idx = 4 * k;
            if (idx + 3 < nrec && idx + 3 < 2048) begin
                for (int j = 1; j < 4; j++)
                    if (rec[idx + j] != rec[idx]) unstable++;
                if (k <= 12 || k >= periods - FL - 1)
                    check_val($sformatf("%s_sym_p%0d", tag, k), int'(rec[idx]), exp_sym(k, len));
                else if (int'(rec[idx]) != exp_sym(k, len))
                    unstable++;
            end else begin
                unstable++;
            end
        end
        check_val({tag, "_sym_stable"}, unstable, 0);
    endtask

    initial begin
        fill_default();
        #1;
        check_val("rst_us_en", int'(us_en), 0);
        check_val("rst_us_sym", int'(us_sym), 0);
        check_val("rst_sym_ready", int'(sym_ready), 0);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_done", int'(done), 0);
        check_val("rst_underrun", int'(underrun), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        syms[0] = 2'd3; syms[1] = 2'd1; syms[2] = 2'd2;
        run_frame(3);
        verify("len3", 3);
        check_val("len3_underrun", int'(underrun), 0);

        fill_default();
        run_frame(2);
        verify("len2", 2);

        vld[1] = 1'b0;
        run_frame(4);
        verify("len4_starve", 4);
        check_val("starve_underrun_set", int'(underrun), 1);
        repeat (5) @(negedge clk);
        check_val("starve_underrun_sticky", int'(underrun), 1);
        fill_default();
        run_frame(1);
        check_val("start_clears_underrun", first_und, 0);
        verify("len1", 1);

        run_frame(0);
        verify("len0", 0);

        restart_at = 6;
        run_frame(2);
        restart_at = -1;
        verify("start_while_busy", 2);

        @(negedge clk);
        frame_len = 8'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4 * (1 + P) + 1) @(negedge clk);
        check_val("pre_abort_busy", int'(busy), 1);
        rst = 1'b1;
        #1;
        check_val("abort_us_en", int'(us_en), 0);
        check_val("abort_us_sym", int'(us_sym), 0);
        check_val("abort_sym_ready", int'(sym_ready), 0);
        check_val("abort_busy", int'(busy), 0);
        check_val("abort_done", int'(done), 0);
        begin
            int dc;
            dc = 0;
            repeat (3) @(negedge clk) if (done) dc++;
            rst = 1'b0;
            repeat (6) @(negedge clk) if (done || us_en) dc++;
            check_val("abort_no_done", dc, 0);
        end
        syms[0] = 2'd2; syms[1] = 2'd3; syms[2] = 2'd1;
        run_frame(3);
        verify("after_abort", 3);

        fill_default();
        run_frame(255);
        verify("len255", 255);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
